imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Registered, parametrised successor to the combinational immediate generator.
- Accepts 32-bit RV instructions over a valid/ready handshake and extracts the immediate, sign- or zero-extended to XLEN.
- Adds shift-amount and CSR zimm formats plus a format code.
- Presents results from a 2-entry skid buffer, so the decode stage can sit between fetch and register-read with full throughput and registered ready.

Parameters:
- XLEN, 32, datapath width of imm_o. Legal values: 32 or 64.
- SHW, (XLEN==64 ? 6 : 5), shamt field width. Derived; not overridden.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  discard all buffered entries (pipeline redirect).
- in_valid_i  in  1  instr_i is valid.
- in_ready_o  out  1  stage can accept; registered.
- instr_i  in  32  instruction word.
- out_valid_o  out  1  output entry is valid.
- out_ready_i  in  1  consumer accepts the output entry.
- instr_o  out  32  instruction of the output entry.
- imm_o  out  XLEN  decoded immediate of the output entry.
- fmt_o  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.

Behaviour:
- Decode (combinational, on instr_i before capture; E = sign-extend to XLEN from instr[31]):
  - 0000011, 1100111: I; 0010011: I unless funct3 is 001 or 101.
  - 0010011 with funct3 001/101: SHAMT, imm = zero-extend instr[20+SHW-1:20]. Bits 30/25 do not affect imm.
  - 0100011: S, E{instr[31:25], instr[11:7]}.
  - 1100011: B, E{instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 0110111, 0010111: U, E{instr[31:12], 12'b0}. Upper bits are sign-filled when XLEN=64.
  - 1101111: J, E{instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 1110011 with funct3[2]=1: ZIMM, zero-extend instr[19:15].
  - Any other opcode: NONE, imm 0.
- Storage: main register (drives outputs) plus skid register. Each entry holds {instr, imm, fmt}. Count is 0..2.
- Accept rule: accept = in_valid_i & in_ready_o. Pop rule: pop = out_valid_o & out_ready_i.
- Ordering: FIFO order is strict. After a pop, the skid entry moves to main before any new entry.
- Latency: 1 cycle. An entry accepted at edge N into an empty stage gives out_valid_o=1 after edge N.
- Throughput: 1 per cycle while out_ready_i=1.
- Ready: in_ready_o is registered and equals (count_next < 2). It is low only while both entries are held.
  - The skid register absorbs the one accept that lands in the cycle the consumer stalls.
  - Accept and pop in the same cycle leave count unchanged.
- Overflow: never occurs. in_valid_i while in_ready_o=0 is ignored; no state change.
- Output stability: while out_valid_o=1 and out_ready_i=0, instr_o/imm_o/fmt_o are held stable.
- Flush: flush_i=1 at an edge sets count to 0, out_valid_o=0 and in_ready_o=1.
  - A simultaneous accept is dropped; flush wins over accept and pop.
  - Output data registers may retain stale values.
- Reset: rst_i=1 at an edge produces out_valid_o=0, in_ready_o=1, instr_o=0, imm_o=0, fmt_o=0, count=0.
  - Reset has priority over flush and handshakes.
  - Reset mid-stall drops all entries.
- No combinational path from out_ready_i to in_ready_o.

Test Plan:
- XLEN=32, accept 0xFFF00093 (addi x1,x0,-1) with out_ready_i=1 -> next cycle out_valid_o=1, imm_o=0xFFFFFFFF, fmt_o=1.
- XLEN=32, accept 0xFE000EE3 (beq -4) -> imm_o=0xFFFFFFFC, fmt_o=3. Then accept 0x3002D073 (csrrwi, zimm 5) -> imm_o=0x00000005, fmt_o=7.
- XLEN=64:
  - 0x800000B7 (lui 0x80000) -> imm_o=0xFFFFFFFF80000000, fmt_o=4.
  - 0x03F09093 (slli x1,x1,63) -> imm_o=63, fmt_o=6.
  - 0x43F0D093 (srai 63) -> imm_o=63.
- Backpressure: out_ready_i=0, drive 3 back-to-back instrs A, B, C -> A and B accepted, in_ready_o=0 after the second accept, C held off. Raise out_ready_i -> A, B, C delivered in order, no duplicate or loss, in_ready_o back to 1.
- Flush with 2 entries held plus a simultaneous valid input -> next cycle out_valid_o=0, in_ready_o=1. Neither the held entries nor the input ever appear on the output.
- Assert rst_i for 1 cycle mid-stream (count=2) -> all outputs at reset values next cycle. The first post-reset accept is delivered with 1-cycle latency.

Source files
------------

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered RV immediate decode stage with 2-entry skid buffer
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     raw;
  logic            sext;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;
  entry_t          dec;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // raw holds the 32-bit immediate; sext decides whether bit 31 fills the upper XLEN bits
  always_comb begin
    raw     = '0;
    sext    = 1'b1;
    dec_fmt = FMT_NONE;
    case (opcode)
      7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        raw     = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      7'b0010011: begin
        if (funct3[1:0] == 2'b01) begin
          dec_fmt         = FMT_SHAMT;
          sext            = 1'b0;
          raw[SHW-1:0]    = instr_i[20 +: SHW];
        end else begin
          dec_fmt = FMT_I;
          raw     = {{20{instr_i[31]}}, instr_i[31:20]};
        end
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        raw     = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        raw     = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        raw     = {instr_i[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        raw     = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      7'b1110011: begin
        if (funct3[2]) begin
          dec_fmt = FMT_ZIMM;
          sext    = 1'b0;
          raw     = {27'b0, instr_i[19:15]};
        end
      end
      default: begin
        dec_fmt = FMT_NONE;
      end
    endcase
  end

  always_comb begin
    dec_imm       = {XLEN{sext & raw[31]}};
    dec_imm[31:0] = raw;
  end

  assign dec = {instr_i, dec_imm, dec_fmt};

  entry_t main_q, skid_q, main_d, skid_d;
  logic   main_vld_q, skid_vld_q, main_vld_d, skid_vld_d;
  logic   ready_q;
  logic   accept, pop;

  assign accept = in_valid_i & ready_q;
  assign pop    = main_vld_q & out_ready_i;

  // skid is only ever occupied while main is; it refills main on the next pop
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (pop) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = accept;
        if (accept) skid_d = dec;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      if (main_vld_q) begin
        skid_d     = dec;
        skid_vld_d = 1'b1;
      end else begin
        main_d     = dec;
        main_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      ready_q    <= ~(main_vld_d & skid_vld_d);
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_vld_q;
  assign instr_o     = main_q.instr;
  assign imm_o       = main_q.imm;
  assign fmt_o       = main_q.fmt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - random and directed checks of imm_decode_stage at XLEN 32 and 64
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;

  logic        rdy32, ov32, rdy64, ov64;
  logic [31:0] instr32, instr64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q[$];

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy32),
    .instr_i(instr), .out_valid_o(ov32), .out_ready_i(out_ready), .instr_o(instr32),
    .imm_o(imm32), .fmt_o(fmt32)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy64),
    .instr_i(instr), .out_valid_o(ov64), .out_ready_i(out_ready), .instr_o(instr64),
    .imm_o(imm64), .fmt_o(fmt64)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint fld(input logic [31:0] w, input int lo, input int n);
    return longint'((w >> lo) & ((32'd1 << n) - 1));
  endfunction

  // immediate rebuilt arithmetically from field weights, as a signed integer
  function automatic void ref_decode(input logic [31:0] ins, input int xlen,
                                     output logic [63:0] imm, output logic [2:0] fmt);
    longint s, v;
    logic [6:0] op;
    logic [2:0] f3;
    s  = longint'($signed(ins));
    op = ins[6:0];
    f3 = ins[14:12];
    v  = 0;
    fmt = 3'd0;
    case (op)
      7'b0000011, 7'b1100111: begin fmt = 3'd1; v = s >>> 20; end
      7'b0010011: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin fmt = 3'd6; v = fld(ins, 20, 12) % xlen; end
        else begin fmt = 3'd1; v = s >>> 20; end
      end
      7'b0100011: begin fmt = 3'd2; v = (s >>> 25) * 32 + fld(ins, 7, 5); end
      7'b1100011: begin
        fmt = 3'd3;
        v = (s >>> 31) * 4096 + fld(ins, 7, 1) * 2048 + fld(ins, 25, 6) * 32 + fld(ins, 8, 4) * 2;
      end
      7'b0110111, 7'b0010111: begin fmt = 3'd4; v = (s >>> 12) * 4096; end
      7'b1101111: begin
        fmt = 3'd5;
        v = (s >>> 31) * 1048576 + fld(ins, 12, 8) * 4096 + fld(ins, 20, 1) * 2048 + fld(ins, 21, 10) * 2;
      end
      7'b1110011: if (f3 >= 3'd4) begin fmt = 3'd7; v = fld(ins, 15, 5); end
      default: v = 0;
    endcase
    imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                      input logic fl, input logic rs);
    logic acc, pop;
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    in_valid = v; instr = ins; out_ready = ordy; flush = fl; rst = rs;
    @(posedge clk);
    acc = v && (q.size() < 2);
    pop = (q.size() > 0) && ordy;
    if (rs || fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ins);
    end
    #1;
    check_eq("ready32", rdy32, q.size() < 2);
    check_eq("ready64", rdy64, q.size() < 2);
    check_eq("valid32", ov32, q.size() > 0);
    check_eq("valid64", ov64, q.size() > 0);
    if (rs) begin
      check_eq("rst instr32", instr32, 0);
      check_eq("rst imm32", imm32, 0);
      check_eq("rst fmt32", fmt32, 0);
      check_eq("rst instr64", instr64, 0);
      check_eq("rst imm64", imm64, 0);
      check_eq("rst fmt64", fmt64, 0);
    end
    if (q.size() > 0) begin
      check_eq("instr32", instr32, q[0]);
      check_eq("instr64", instr64, q[0]);
      ref_decode(q[0], 32, e_imm, e_fmt);
      check_eq("imm32", imm32, e_imm);
      check_eq("fmt32", fmt32, e_fmt);
      ref_decode(q[0], 64, e_imm, e_fmt);
      check_eq("imm64", imm64, e_imm);
      check_eq("fmt64", fmt64, e_fmt);
    end
  endtask

  logic [6:0] ops [10] = '{7'b0000011, 7'b1100111, 7'b0010011, 7'b0100011, 7'b1100011,
                           7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011};

  initial begin
    logic [31:0] r;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    step(1, 32'hFFF00093, 1, 0, 0);
    check_eq("addi imm32", imm32, 64'hFFFFFFFF);
    check_eq("addi fmt", fmt32, 1);
    step(1, 32'hFE000EE3, 1, 0, 0);
    check_eq("beq imm32", imm32, 64'hFFFFFFFC);
    check_eq("beq fmt", fmt32, 3);
    step(1, 32'h3002D073, 1, 0, 0);
    check_eq("csrrwi imm32", imm32, 64'h5);
    check_eq("csrrwi fmt", fmt32, 7);
    step(1, 32'h800000B7, 1, 0, 0);
    check_eq("lui imm64", imm64, 64'hFFFFFFFF80000000);
    check_eq("lui fmt", fmt64, 4);
    step(1, 32'h03F09093, 1, 0, 0);
    check_eq("slli imm64", imm64, 64'd63);
    check_eq("slli fmt", fmt64, 6);
    step(1, 32'h43F0D093, 1, 0, 0);
    check_eq("srai imm64", imm64, 64'd63);
    step(0, 0, 1, 0, 0);

    step(1, 32'h00500113, 0, 0, 0);
    check_eq("bp ready after A", rdy32, 1);
    step(1, 32'h00112023, 0, 0, 0);
    check_eq("bp ready after B", rdy32, 0);
    step(1, 32'h0000006F, 0, 0, 0);
    check_eq("bp A held", instr32, 32'h00500113);
    step(1, 32'h0000006F, 1, 0, 0);
    check_eq("bp B next", instr32, 32'h00112023);
    step(1, 32'h0000006F, 1, 0, 0);
    check_eq("bp C last", instr32, 32'h0000006F);
    step(0, 0, 1, 0, 0);
    check_eq("bp drained ready", rdy32, 1);

    step(1, 32'h00100093, 0, 0, 0);
    step(1, 32'h00200093, 0, 0, 0);
    step(1, 32'h00300093, 0, 1, 0);
    check_eq("flush valid", ov64, 0);
    check_eq("flush ready", rdy64, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    step(1, 32'h00400093, 0, 0, 0);
    step(1, 32'h00500093, 0, 0, 0);
    step(1, 32'h00600093, 0, 0, 1);
    check_eq("rst valid", ov32, 0);
    step(1, 32'h00700093, 1, 0, 0);
    check_eq("post-rst valid", ov32, 1);
    check_eq("post-rst instr", instr32, 32'h00700093);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 9)];
      step(($urandom % 4) != 0, r, ($urandom % 3) != 0,
           ($urandom % 64) == 0, ($urandom % 256) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
